mux_arb_n: RTL and testbench

//  Parametrised N-channel, W-bit registered multiplexer with valid/ready handshake.

---
 rtl/mux_arb_n.sv | 96 +++++++++
 tb/tb_mux_arb_n.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mux_arb_n.sv
// N-channel registered mux with valid/ready handshake and fixed-select or round-robin grant.
// Optional MUX_ARB_STATS_EN adds saturating transfer and stall counters.
module mux_arb_n #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NCH   = 4,
  parameter int unsigned SELW  = 2
) (
  input  logic                  clk,
  input  logic                  rst_f,
  input  logic [NCH*WIDTH-1:0]  in_data,
  input  logic [NCH-1:0]        in_valid,
  output logic [NCH-1:0]        in_ready,
  input  logic                  mode,
  input  logic [SELW-1:0]       sel,
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       out_ch,
  output logic                  out_valid,
`ifdef MUX_ARB_STATS_EN
  output logic [15:0]           xfer_cnt,
  output logic [15:0]           stall_cnt,
`endif
  input  logic                  out_ready
);

  localparam int unsigned CNTW = 16;

  logic [SELW-1:0] rr_ptr;
  logic [SELW-1:0] gnt;
  logic [SELW-1:0] idx;
  logic            gnt_vld;
  logic            can_load;
  logic            xfer;

  assign can_load = ~out_valid | out_ready;

  // Grant selection: fixed index in mode 0, rotating scan after rr_ptr in mode 1
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = '0;
    if (!mode) begin
      if ((32'(sel) < NCH) && in_valid[sel]) begin
        gnt_vld = 1'b1;
        gnt     = sel;
      end
    end else begin
      for (int unsigned k = 1; k <= NCH; k++) begin
        idx = SELW'((32'(rr_ptr) + k) % NCH);
        if (!gnt_vld && in_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt     = idx;
        end
      end
    end
  end

  // Reset gates the handshake so no source sees an accept while the block is held
  assign xfer = gnt_vld & can_load & rst_f;

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= SELW'(NCH - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[32'(gnt)*WIDTH +: WIDTH];
      out_ch    <= gnt;
      if (mode) rr_ptr <= gnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_ARB_STATS_EN
  // Saturating activity counters
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      xfer_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (xfer && (xfer_cnt != {CNTW{1'b1}}))
        xfer_cnt <= xfer_cnt + CNTW'(1);
      if (out_valid && !out_ready && (stall_cnt != {CNTW{1'b1}}))
        stall_cnt <= stall_cnt + CNTW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed self-checking bench for mux_arb_n (4 channels, 32-bit).
module tb_mux_arb_n;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NCH   = 4;
  localparam int unsigned SELW  = 2;

  logic                 clk = 1'b0;
  logic                 rst_f;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;
  logic                 out_valid;
  logic                 out_ready;
`ifdef MUX_ARB_STATS_EN
  logic [15:0]          xfer_cnt;
  logic [15:0]          stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  mux_arb_n #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
    .clk       (clk),
    .rst_f     (rst_f),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
`ifdef MUX_ARB_STATS_EN
    .xfer_cnt  (xfer_cnt),
    .stall_cnt (stall_cnt),
`endif
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] chv(input int i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  initial begin
    for (int i = 0; i < int'(NCH); i++) in_data[i*WIDTH +: WIDTH] = chv(i);
    rst_f = 1'b0; in_valid = 4'b1111; out_ready = 1'b1; mode = 1'b0; sel = 2'd0;

    // Reset with all sources requesting
    tick(); tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  out_data, 32'd0);
    check("rst_ch",    32'(out_ch), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);

    rst_f = 1'b1; in_valid = 4'b0000;
    tick();
    check("idle_valid", 32'(out_valid), 32'd0);

    // Fixed select of channel 2
    sel = 2'd2; in_valid = 4'b0100; #1;
    check("fix_ready", 32'(in_ready), 32'h4);
    tick();
    check("fix_data",  out_data, 32'hA5A5_0002);
    check("fix_ch",    32'(out_ch), 32'd2);
    check("fix_valid", 32'(out_valid), 32'd1);
    in_valid = 4'b0000;
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_hold",  out_data, 32'hA5A5_0002);

    // Round robin, all requesting: 0,1,2,3,0
    mode = 1'b1; in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rr_ch",   32'(out_ch), 32'(i % 4));
      check("rr_data", out_data, chv(i % 4));
    end

    // Load ch1, then backpressure for 3 cycles
    tick();
    check("bp_ch", 32'(out_ch), 32'd1);
    out_ready = 1'b0; #1;
    check("bp_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_data",  out_data, chv(1));
      check("bp_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1; #1;
    check("bp_rel_ready", 32'(in_ready), 32'h4);
    tick();
    check("bp_rel_ch",   32'(out_ch), 32'd2);
    check("bp_rel_data", out_data, chv(2));

    // Fixed select of an idle channel: no grant, output drains
    mode = 1'b0; sel = 2'd3; in_valid = 4'b0111; #1;
    check("nogrant_ready", 32'(in_ready), 32'd0);
    tick();
    check("nogrant_valid", 32'(out_valid), 32'd0);

    // Sparse round robin with wrap; rr_ptr is 2 from the last mode-1 transfer
    mode = 1'b1; in_valid = 4'b1001; #1;
    check("rr_sparse_ready3", 32'(in_ready), 32'h8);
    tick();
    check("rr_sparse_ch3", 32'(out_ch), 32'd3);
    check("rr_wrap_ready0", 32'(in_ready), 32'h1);
    tick();
    check("rr_wrap_ch0", 32'(out_ch), 32'd0);

    // Reset while a word is held under backpressure
    out_ready = 1'b0; tick();
    rst_f = 1'b0; tick();
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data",  out_data, 32'd0);
    rst_f = 1'b1; out_ready = 1'b1;

`ifdef MUX_ARB_STATS_EN
    check("cnt_rst_x", 32'(xfer_cnt), 32'd0);
    check("cnt_rst_s", 32'(stall_cnt), 32'd0);
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001;
    for (int i = 0; i < 5; i++) tick();
    in_valid = 4'b0000; out_ready = 1'b0;
    tick(); tick();
    check("cnt_xfer",  32'(xfer_cnt), 32'd5);
    check("cnt_stall", 32'(stall_cnt), 32'd2);
    rst_f = 1'b0; tick();
    check("cnt_clr_x", 32'(xfer_cnt), 32'd0);
    check("cnt_clr_s", 32'(stall_cnt), 32'd0);
    rst_f = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
